// File: rtl/fifo_param.sv
// ---------------------------------------------------------------------------
// fifo_param
// Parameterised synchronous FIFO with first-word fall-through output,
// almost-full / almost-empty flags and registered overflow / underflow pulses.
//
// Parameters
//   width  : data word width in bits
//   depth  : number of storage entries (any value >= 2)
//   af_th  : almost_full asserts when free entries <= af_th
//   ae_th  : almost_empty asserts when occupancy <= ae_th
//   mode   : behaviour of a push into a full FIFO (0 = drop, 1 = overwrite oldest)
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : asynchronous active-high reset
//   push         : write request, dato_in captured on the same edge
//   pop          : read request, consumes the head word
//   dato_in      : write data
//   dato_out     : head word, forced to 0 while the FIFO is empty
//   pndng        : FIFO holds at least one word
//   full         : count == depth
//   almost_full  : count >= depth - af_th
//   almost_empty : count <= ae_th
//   overflow     : one-cycle pulse after a push (without pop) into a full FIFO
//   underflow    : one-cycle pulse after a pop from an empty FIFO
//   count        : current occupancy
// ---------------------------------------------------------------------------
module fifo_param #(
    parameter int width = 16,
    parameter int depth = 16,
    parameter int af_th = 2,
    parameter int ae_th = 2,
    parameter int mode  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [width-1:0]             dato_in,
    output logic [width-1:0]             dato_out,
    output logic                         pndng,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int CW = $clog2(depth + 1);
    localparam int PW = $clog2(depth);

    localparam logic [CW-1:0] FULL_LEVEL = CW'(depth);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(depth - af_th);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(ae_th);
    localparam logic [PW-1:0] LAST_IDX   = PW'(depth - 1);

    logic [width-1:0] mem [depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             is_empty;
    logic             is_full;
    logic             do_write;
    logic             do_advance_rd;

    // Pointers wrap explicitly at depth-1 so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    // Status flags depend only on the registered occupancy.
    assign is_empty     = (count == '0);
    assign is_full      = (count == FULL_LEVEL);
    assign pndng        = !is_empty;
    assign full         = is_full;
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);
    assign dato_out     = pndng ? mem[rd_ptr] : '0;

    // A write lands when there is room, when a simultaneous pop frees the
    // head slot, or when overwrite mode sacrifices the oldest word. The read
    // pointer moves on a real pop, and also on an overwrite so that the
    // oldest word is the one that disappears.
    always_comb begin
        do_write      = push && (!is_full || pop || (mode == 1));
        do_advance_rd = (pop && !is_empty) || (push && !pop && is_full && (mode == 1));
        count_next    = count;
        case ({do_write, do_advance_rd})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Pointer, occupancy and error-pulse registers. The pulses are recomputed
    // every edge, so each lasts exactly one cycle after the offending request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_advance_rd) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count     <= count_next;
            overflow  <= push && !pop && is_full;
            underflow <= pop && is_empty;
        end
    end

    // Storage is deliberately left out of reset; the empty flag masks any
    // stale contents on dato_out.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= dato_in;
        end
    end

endmodule

// File: tb/tb_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_fifo_param
// Self-checking bench for fifo_param (width=16, depth=4, af_th=1, ae_th=1).
// Two instances share the same stimulus: one in drop mode, one in overwrite
// mode. Each is compared against a queue-based reference model every cycle,
// and a table of hand-computed vectors pins down the directed scenarios.
// ---------------------------------------------------------------------------
module tb_fifo_param;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int AF_TH = 1;
    localparam int AE_TH = 1;

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] dato_in;

    logic [WIDTH-1:0] dout0, dout1;
    logic             pndng0, pndng1, full0, full1, af0, af1, ae0, ae1;
    logic             ovf0, ovf1, unf0, unf1;
    logic [2:0]       count0, count1;

    int errors = 0;
    int checks = 0;

    // Reference model state: one queue per overflow policy, plus the
    // registered error pulses as they should appear after the last edge.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    logic             m_ovf0, m_unf0, m_ovf1, m_unf1;

    fifo_param #(.width(WIDTH), .depth(DEPTH), .af_th(AF_TH), .ae_th(AE_TH), .mode(0)) dut0 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .dato_in(dato_in),
        .dato_out(dout0), .pndng(pndng0), .full(full0), .almost_full(af0),
        .almost_empty(ae0), .overflow(ovf0), .underflow(unf0), .count(count0)
    );

    fifo_param #(.width(WIDTH), .depth(DEPTH), .af_th(AF_TH), .ae_th(AE_TH), .mode(1)) dut1 (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .dato_in(dato_in),
        .dato_out(dout1), .pndng(pndng1), .full(full1), .almost_full(af1),
        .almost_empty(ae1), .overflow(ovf1), .underflow(unf1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors for the drop-mode and overwrite-mode instances.
    typedef struct {
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] din;
        int               exp_count;
        logic [WIDTH-1:0] exp_dout0;
        logic [WIDTH-1:0] exp_dout1;
        logic             exp_ovf;
        logic             exp_unf;
        logic             exp_full;
        logic             exp_af;
        logic             exp_ae;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        q0.delete();
        q1.delete();
        m_ovf0 = 1'b0;
        m_unf0 = 1'b0;
        m_ovf1 = 1'b0;
        m_unf1 = 1'b0;
    endtask

    // Behaviour at one rising edge: a pop (if anything is there) happens
    // first, then the push either fits, is dropped, or evicts the oldest.
    task automatic modelStep(input logic p, input logic o, input logic [WIDTH-1:0] d);
        m_ovf0 = p && !o && (q0.size() == DEPTH);
        m_unf0 = o && (q0.size() == 0);
        if (o && q0.size() > 0) void'(q0.pop_front());
        if (p && q0.size() < DEPTH) q0.push_back(d);

        m_ovf1 = p && !o && (q1.size() == DEPTH);
        m_unf1 = o && (q1.size() == 0);
        if (o && q1.size() > 0) void'(q1.pop_front());
        if (p) begin
            if (q1.size() == DEPTH) void'(q1.pop_front());
            q1.push_back(d);
        end
    endtask

    // Drives one cycle of inputs from a falling edge, updates the model on
    // the rising edge and returns at the next falling edge for sampling.
    task automatic applyStimulus(input logic p, input logic o, input logic [WIDTH-1:0] d);
        push    = p;
        pop     = o;
        dato_in = d;
        @(posedge clk);
        modelStep(p, o, d);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic checkOutput();
        int s0, s1;
        s0 = q0.size();
        s1 = q1.size();
        chk("m0_count", int'(count0), s0);
        chk("m0_dout", int'(dout0), (s0 > 0) ? int'(q0[0]) : 0);
        chk("m0_pndng", int'(pndng0), int'(s0 > 0));
        chk("m0_full", int'(full0), int'(s0 == DEPTH));
        chk("m0_af", int'(af0), int'(s0 >= DEPTH - AF_TH));
        chk("m0_ae", int'(ae0), int'(s0 <= AE_TH));
        chk("m0_ovf", int'(ovf0), int'(m_ovf0));
        chk("m0_unf", int'(unf0), int'(m_unf0));
        chk("m1_count", int'(count1), s1);
        chk("m1_dout", int'(dout1), (s1 > 0) ? int'(q1[0]) : 0);
        chk("m1_pndng", int'(pndng1), int'(s1 > 0));
        chk("m1_full", int'(full1), int'(s1 == DEPTH));
        chk("m1_af", int'(af1), int'(s1 >= DEPTH - AF_TH));
        chk("m1_ae", int'(ae1), int'(s1 <= AE_TH));
        chk("m1_ovf", int'(ovf1), int'(m_ovf1));
        chk("m1_unf", int'(unf1), int'(m_unf1));
    endtask

    initial begin
        //             push  pop   din       cnt dout0    dout1    ovf   unf   full  af    ae
        vecs[0]  = '{1'b1, 1'b0, 16'h000A, 1, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 16'h000B, 2, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h000C, 3, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h000D, 4, 16'h000A, 16'h000A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h00EE, 4, 16'h000A, 16'h000B, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 3, 16'h000B, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 2, 16'h000C, 16'h000D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 1, 16'h000D, 16'h00EE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 16'h0011, 1, 16'h0011, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1, 16'h0011, 16'h0011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst     = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        dato_in = '0;
        modelReset();
        repeat (2) @(negedge clk);
        $display("[TB] checking reset state");
        checkOutput();
        rst = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din);
            checkOutput();
            chk($sformatf("vec%0d_count0", i), int'(count0), vecs[i].exp_count);
            chk($sformatf("vec%0d_count1", i), int'(count1), vecs[i].exp_count);
            chk($sformatf("vec%0d_dout0", i), int'(dout0), int'(vecs[i].exp_dout0));
            chk($sformatf("vec%0d_dout1", i), int'(dout1), int'(vecs[i].exp_dout1));
            chk($sformatf("vec%0d_ovf", i), int'(ovf0), int'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d_unf", i), int'(unf1), int'(vecs[i].exp_unf));
            chk($sformatf("vec%0d_full", i), int'(full0), int'(vecs[i].exp_full));
            chk($sformatf("vec%0d_af", i), int'(af1), int'(vecs[i].exp_af));
            chk($sformatf("vec%0d_ae", i), int'(ae0), int'(vecs[i].exp_ae));
        end

        // Fill to full, then push+pop on a full FIFO and keep streaming so
        // both pointers wrap several times with data staying in order.
        $display("[TB] push+pop while full and pointer wrap");
        applyStimulus(1'b1, 1'b0, 16'h000B);
        applyStimulus(1'b1, 1'b0, 16'h000C);
        applyStimulus(1'b1, 1'b0, 16'h000D);
        checkOutput();
        applyStimulus(1'b1, 1'b1, 16'h0022);
        checkOutput();
        chk("fullpp_count", int'(count0), 4);
        chk("fullpp_ovf0", int'(ovf0), 0);
        chk("fullpp_ovf1", int'(ovf1), 0);
        chk("fullpp_head", int'(dout0), 16'h000B);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0030 + 16'(i));
            checkOutput();
        end
        chk("wrap_head", int'(dout1), 16'h0034);

        // Asynchronous reset between edges with three words stored.
        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b0, 1'b1, 16'h0000);
        chk("prerst_count", int'(count0), 3);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        chk("asyncrst_count", int'(count1), 0);
        chk("asyncrst_ae", int'(ae0), 1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0055);
        checkOutput();
        chk("postrst_count", int'(count0), 1);
        chk("postrst_dout", int'(dout0), 16'h0055);

        // Random traffic, alternating between push-heavy and pop-heavy
        // stretches so the FIFO regularly reaches both full and empty.
        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic p, o;
            int   bias;
            bias = ((i / 40) % 2 == 0) ? 75 : 25;
            p = ($urandom_range(99) < bias);
            o = ($urandom_range(99) >= bias);
            applyStimulus(p, o, 16'($urandom));
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
FIFO_PARAM -- requirements
Module: fifo_param

Interface
REQ-001 Parameter width, default 16, data word width in bits (>=1).
REQ-002 Parameter depth, default 16, number of storage entries (>=2, power of two not required).
REQ-003 Parameter af_th, default 2, almost_full threshold: free entries remaining at which almost_full asserts (0..depth-1).
REQ-004 Parameter ae_th, default 2, almost_empty threshold: occupancy at or below which almost_empty asserts (0..depth-1).
REQ-005 Parameter mode, default 0, full-write policy: 0 = drop new word, 1 = overwrite oldest word.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 push  input  1  write request; dato_in is captured on the same edge.
REQ-009 pop  input  1  read request; consumes the head word.
REQ-010 dato_in  input  width  write data.
REQ-011 dato_out  output  width  head word (first-word fall-through).
REQ-012 pndng  output  1  FIFO non-empty.
REQ-013 full  output  1  count == depth.
REQ-014 almost_full  output  1  count >= depth - af_th.
REQ-015 almost_empty  output  1  count <= ae_th.
REQ-016 overflow  output  1  one-cycle pulse: push while full without pop.
REQ-017 underflow  output  1  one-cycle pulse: pop while empty.
REQ-018 count  output  $clog2(depth+1)  current occupancy.

Function
REQ-019 The block SHALL store words in a circular array indexed by write and read pointers; each pointer wraps from depth-1 to 0.
REQ-020 dato_out SHALL equal the entry at the read pointer when pndng=1 and SHALL be 0 when pndng=0; no read latency.
REQ-021 pndng, full, almost_full, almost_empty SHALL be combinational functions of the registered count only.
REQ-022 push only, not full: word written at write pointer, write pointer +1, count +1.
REQ-023 pop only, not empty: read pointer +1, count -1; dato_out shows the next word on the following cycle.
REQ-024 push and pop, 0 < count < depth: both pointers advance, count unchanged.
REQ-025 push and pop, count == depth: pop and write both succeed, count stays depth, overflow stays 0 (both modes).
REQ-026 push and pop, count == 0: write succeeds, pop ignored, count becomes 1, underflow pulses 1.
REQ-027 pop only, count == 0: no state change, underflow pulses 1 on the next cycle.
REQ-028 push only, count == depth, mode 0: word discarded, no state change, overflow pulses 1.
REQ-029 push only, count == depth, mode 1: word written at write pointer, both pointers +1 (oldest dropped), count stays depth, overflow pulses 1.
REQ-030 overflow and underflow SHALL be registered, asserted for exactly the cycle after the offending edge, and cleared otherwise.
REQ-031 count SHALL never exceed depth nor go below 0.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force pointers=0, count=0, overflow=0, underflow=0.
REQ-033 During and after reset: pndng=0, full=0, almost_full=0, almost_empty=1, dato_out=0; storage array contents are not reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored words; push/pop on the first edge after deassertion SHALL be honoured normally.

Verification (width=16, depth=4, af_th=1, ae_th=1)
REQ-035 Reset, push 0x000A,0x000B,0x000C,0x000D -> count 1..4, almost_full at count 3, full at 4, dato_out=0x000A throughout.
REQ-036 mode 0, full, push 0x00EE -> overflow=1 one cycle, count=4; 4 pops return 0x000A,0x000B,0x000C,0x000D, then pndng=0, dato_out=0.
REQ-037 mode 1, full with A..D, push 0x00EE -> overflow=1, count=4, pops return 0x000B,0x000C,0x000D,0x00EE.
REQ-038 Empty, pop -> underflow=1 one cycle, count=0; empty, push 0x0011 with pop -> underflow=1, count=1, dato_out=0x0011.
REQ-039 Full, push 0x0022 with pop -> count=4, overflow=0, head advances; 8 further push+pop cycles exercise pointer wrap with data in order.
REQ-040 count=3, assert rst between clock edges -> count=0, pndng=0, almost_empty=1 before the next rising edge.
